// File: rtl/lfsr_run_ctrl.sv
// lfsr_run_ctrl: runs a Fibonacci LFSR for a programmed number of steps per job
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start_i     job request, sampled only in IDLE
//   seed_i      initial LFSR value, captured with start_i
//   count_i     number of valid outputs per job, captured with start_i
//   hold_i      freezes LFSR and step counter while running
//   abort_i     ends a job in LOAD/RUN without a done pulse
//   op_o        current LFSR register
//   valid_o     op_o is a counted output this cycle
//   busy_o      a job is in LOAD or RUN
//   done_o      one-cycle pulse at job completion
//   seed_err_o  last accepted seed was all-zero and was replaced by 1
//   wrap_o      LFSR period boundary pulse (only with LFSR_WRAP_DET_EN defined, else 0)
//
// Optional feature macro: LFSR_WRAP_DET_EN
module lfsr_run_ctrl #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS = 4'b1001,
    parameter int              CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             hold_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] op_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             seed_err_o,
    output logic             wrap_o
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             seed_err_q, seed_err_d;
    logic [WIDTH-1:0] san_seed;
    logic [WIDTH-1:0] lfsr_step;

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    assign san_seed  = (seed_q == '0) ? WIDTH'(1) : seed_q;
    assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        seed_d     = seed_q;
        cnt_d      = cnt_q;
        count_d    = count_q;
        seed_err_d = seed_err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    seed_d  = seed_i;
                    count_d = count_i;
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    lfsr_d     = san_seed;
                    seed_err_d = (seed_q == '0);
                    cnt_d      = '0;
                    state_d    = (count_q != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // abort outranks both hold and the terminal count
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (!hold_i) begin
                    lfsr_d  = lfsr_step;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == count_q - CNT_W'(1)) ? S_DONE : S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= WIDTH'(1);
            seed_q     <= '0;
            cnt_q      <= '0;
            count_q    <= '0;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            seed_q     <= seed_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign op_o       = lfsr_q;
    assign valid_o    = (state_q == S_RUN) & ~hold_i;
    assign busy_o     = (state_q == S_LOAD) | (state_q == S_RUN);
    assign done_o     = (state_q == S_DONE);
    assign seed_err_o = seed_err_q;

`ifdef LFSR_WRAP_DET_EN
    logic [WIDTH-1:0] san_q, san_d;
    logic             match_q, match_d;

    // match_q flags that the upcoming RUN cycle shows the sanitised seed again
    // after at least one step; the pulse itself only fires on a non-hold cycle
    always_comb begin
        san_d   = (state_q == S_LOAD && !abort_i) ? san_seed : san_q;
        match_d = (state_d == S_RUN) && (cnt_d != '0) && (lfsr_d == san_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            san_q   <= WIDTH'(1);
            match_q <= 1'b0;
        end else begin
            san_q   <= san_d;
            match_q <= match_d;
        end
    end

    assign wrap_o = match_q & ~hold_i;
`else
    assign wrap_o = 1'b0;
`endif
endmodule
